// File: rtl/fib_seq_gen.sv
// Additive-recurrence stream source: a <= b, b <= a + b on each accepted term.
// Programmable seeds, optional term limit, wrap/saturate policy and sticky overflow.
module fib_seq_gen #(
    parameter int          WIDTH     = 8,
    parameter int unsigned SEED0     = 0,
    parameter int unsigned SEED1     = 1,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned MAX_TERMS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_a_i,
    input  logic [WIDTH-1:0] load_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             ovf_o,
    output logic             done_o,
    output logic [15:0]      idx_o
);

    // state   | meaning
    // ST_IDLE | stopped; seeds may be loaded, start_i begins a run
    // ST_RUN  | streaming; one term offered per cycle
    // ST_DONE | term limit reached; start_i resumes, load_i reseeds
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = (MAX_TERMS == 0) ? 16'd0 : 16'(MAX_TERMS - 1);
    localparam bit          LIMITED  = (MAX_TERMS != 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [15:0]      r_idx;
    logic             r_ovf;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic [15:0]      w_idx_nxt;
    logic             w_ovf_nxt;

    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_b_adv;
    logic             w_xfer;
    logic             w_last;

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_carry = w_sum[WIDTH];
    assign w_b_adv = (SATURATE && w_carry) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    assign w_xfer  = (r_state == ST_RUN) && out_ready_i;
    assign w_last  = LIMITED && (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= WIDTH'(SEED0);
            r_b     <= WIDTH'(SEED1);
            r_idx   <= 16'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // A load from DONE returns to IDLE unless start_i lifts it straight to RUN.
                if (load_i) begin
                    w_a_nxt     = load_a_i;
                    w_b_nxt     = load_b_i;
                    w_ovf_nxt   = 1'b0;
                    w_idx_nxt   = 16'd0;
                    w_state_nxt = ST_IDLE;
                end
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_idx_nxt   = 16'd0;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    w_a_nxt   = r_b;
                    w_b_nxt   = w_b_adv;
                    w_ovf_nxt = r_ovf | w_carry;
                    w_idx_nxt = r_idx + 16'd1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (stop_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (stop_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_valid_o = (r_state == ST_RUN);
    assign done_o      = (r_state == ST_DONE);
    assign out_data_o  = r_a;
    assign idx_o       = r_idx;
    assign ovf_o       = r_ovf;

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised successor to the two-register accumulate-and-swap sequence machine. It generates a width-configurable additive recurrence: a(n+1) = b(n), b(n+1) = a(n) + b(n). Seeds are programmable at run time, and the block adds a valid/ready output stream, an optional term limit, an overflow policy and a sticky overflow flag. It sits as a stream source feeding downstream datapath or test logic.

## Interface
- WIDTH, 8: term width in bits (≥2).
- SEED0, 0: reset value of a (first term output).
- SEED1, 1: reset value of b.
- SATURATE, 0: 0 = sum wraps modulo 2^WIDTH; 1 = sum clamps to all-ones on carry.
- MAX_TERMS, 0: terms per run before DONE; 0 = unbounded; must be < 2^16.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin or resume streaming (IDLE/DONE only).
- stop_i  in  1  return to IDLE (RUN only).
- load_i  in  1  load seeds (IDLE/DONE only).
- load_a_i  in  WIDTH  seed for a.
- load_b_i  in  WIDTH  seed for b.
- out_valid_o  out  1  term available.
- out_ready_i  in  1  consumer accepts term.
- out_data_o  out  WIDTH  current term, always equal to register a.
- ovf_o  out  1  sticky overflow flag.
- done_o  out  1  high in DONE.
- idx_o  out  16  number of terms transferred in current run.

## Operation
- State registers: a, b (WIDTH), fsm {IDLE, RUN, DONE}, idx (16), ovf.
- Reset values: a=SEED0, b=SEED1, fsm=IDLE, idx=0, ovf=0. Outputs at reset: out_valid_o=0, out_data_o=SEED0, done_o=0, ovf_o=0, idx_o=0.
- out_valid_o = (fsm==RUN). Transfer = out_valid_o & out_ready_i.
- Sum: s = {1'b0,a} + {1'b0,b}, WIDTH+1 bits; carry = s[WIDTH].
- On transfer:
  - a ← b.
  - b ← s[WIDTH-1:0], or all-ones if SATURATE and carry.
  - ovf ← ovf | carry.
  - idx ← idx+1.
- IDLE:
  - load_i: a←load_a_i, b←load_b_i, ovf←0, idx←0.
  - start_i: →RUN, idx←0.
  - load_i and start_i together: both take effect; RUN begins with the loaded seeds.
  - stop_i: ignored.
- RUN:
  - No transfer and stop_i: →IDLE, registers held.
  - Transfer and stop_i: advance, then →IDLE. The transfer is never lost.
  - Transfer with MAX_TERMS≠0 and idx==MAX_TERMS-1: advance, then →DONE. This takes priority over stop_i.
  - start_i and load_i: ignored.
- DONE:
  - out_valid_o=0, done_o=1.
  - start_i: →RUN, idx←0; the sequence continues from current a, b.
  - load_i: loads seeds, clears ovf and idx, →IDLE.
  - load_i and start_i together: load, then →RUN.
- ovf is cleared only by reset or load_i.
- idx wraps at 2^16 when MAX_TERMS=0.

## Timing
- out_data_o, out_valid_o, done_o, ovf_o and idx_o are all registered or directly decoded from registers; none depends combinationally on out_ready_i.
- Start latency: start_i sampled high in cycle t gives out_valid_o=1 in t+1, carrying term a.
- Throughput: one term per cycle while out_ready_i=1.
- Backpressure: while out_ready_i=0, out_data_o and out_valid_o hold stable.
- ovf_o rises in the cycle after the transfer whose sum carried.
- Asynchronous rst mid-RUN: immediate return to reset values; any pending term is discarded.

## Test plan
- Reset defaults, WIDTH=8: start_i pulse, out_ready_i=1 → out_data_o 0,1,1,2,3,5,8,13 on consecutive cycles; idx_o counts 1..8.
- Wrap, SATURATE=0: stream 16 terms → term 13=233, term 14=121 (377 mod 256); ovf_o=1 from the cycle after term 12 (144) transfers; ovf_o stays 1.
- Saturation, SATURATE=1 → terms …,144,233,255,255,255; ovf_o=1.
- Backpressure: hold out_ready_i=0 for 3 cycles after term 5 → out_data_o=5 and out_valid_o=1 stable throughout; the next accepted term is 8.
- MAX_TERMS=5 → exactly 0,1,1,2,3 transferred, then done_o=1, out_valid_o=0. start_i → stream resumes at 5; idx_o restarts at 0.
- Load and stop:
  - In IDLE, load a=3, b=4 together with start_i → 3,4,7,11.
  - stop_i asserted in the same cycle as a transfer of 7 → 7 accepted, then IDLE with out_data_o=11.
  - rst mid-run → out_data_o=SEED0, out_valid_o=0 immediately.
